dram_refresh: RTL and testbench

DRAM_REFRESH -- requirements
Module: dram_refresh

---
 rtl/dram_refresh.sv | 119 +++++++++++
 tb/tb_dram_refresh.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_refresh.sv
// CAS-before-RAS refresh sequencer: a free-running interval divider queues refresh
// requests, and each granted request plays out as CAS setup, RAS pulse and precharge.
module dram_refresh #(
    parameter int REF_DIV  = 512,
    parameter int RAS_CLKS = 3,
    parameter int PRE_CLKS = 2,
    parameter int MAX_PEND = 4
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       ref_gnt,
    output logic       ref_req,
    output logic [3:0] nREF_RAS,
    output logic [3:0] nREF_CAS,
    output logic       ref_busy,
    output logic       ref_done,
    output logic       ref_overrun
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] CBR_CAS = 3'd2;
    localparam logic [2:0] CBR_RAS = 3'd3;
    localparam logic [2:0] PRE     = 3'd4;

    logic [9:0] div;
    logic [2:0] pend;
    logic [2:0] pend_nx;
    logic [2:0] state;
    logic [2:0] state_nx;
    logic [2:0] tmr;
    logic [2:0] tmr_nx;
    logic       tick;
    logic       fin;
    logic       ovr_set;

    assign tick = (div == 10'(REF_DIV - 1));
    assign fin  = (state == PRE) && (tmr == 3'(PRE_CLKS - 1));

    // A tick and a completion on the same edge cancel out.
    always_comb begin
        pend_nx = pend;
        ovr_set = 1'b0;
        if (tick && !fin) begin
            if (pend == 3'(MAX_PEND)) begin
                ovr_set = 1'b1;
            end else begin
                pend_nx = pend + 3'd1;
            end
        end else if (fin && !tick && pend != 3'd0) begin
            pend_nx = pend - 3'd1;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        case (state)
            IDLE: begin
                if (pend != 3'd0) state_nx = REQ;
            end
            REQ: begin
                if (ref_gnt) state_nx = CBR_CAS;
            end
            CBR_CAS: begin
                state_nx = CBR_RAS;
                tmr_nx   = 3'd0;
            end
            CBR_RAS: begin
                if (tmr == 3'(RAS_CLKS - 1)) begin
                    state_nx = PRE;
                    tmr_nx   = 3'd0;
                end else begin
                    tmr_nx = tmr + 3'd1;
                end
            end
            PRE: begin
                if (fin) begin
                    state_nx = (pend_nx != 3'd0) ? REQ : IDLE;
                    tmr_nx   = 3'd0;
                end else begin
                    tmr_nx = tmr + 3'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                tmr_nx   = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output comes straight off a flop.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            div         <= 10'd0;
            pend        <= 3'd0;
            state       <= IDLE;
            tmr         <= 3'd0;
            ref_req     <= 1'b0;
            nREF_RAS    <= 4'hF;
            nREF_CAS    <= 4'hF;
            ref_busy    <= 1'b0;
            ref_done    <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            div         <= tick ? 10'd0 : div + 10'd1;
            pend        <= pend_nx;
            state       <= state_nx;
            tmr         <= tmr_nx;
            ref_req     <= (state_nx != IDLE);
            nREF_RAS    <= (state_nx == CBR_RAS) ? 4'h0 : 4'hF;
            nREF_CAS    <= (state_nx == CBR_CAS || state_nx == CBR_RAS) ? 4'h0 : 4'hF;
            ref_busy    <= (state_nx == CBR_CAS || state_nx == CBR_RAS || state_nx == PRE);
            ref_done    <= fin;
            ref_overrun <= ref_overrun | ovr_set;
        end
    end

endmodule

// File: tb/tb_dram_refresh.sv
// Bench for dram_refresh: directed vectors, multi-cycle corner sequences and a
// randomized run compared each cycle against a queue-based refresh model.
module tb_dram_refresh;

    localparam int REF_DIV  = 16;
    localparam int RAS_CLKS = 3;
    localparam int PRE_CLKS = 2;
    localparam int MAX_PEND = 4;

    logic       clk = 1'b0;
    logic       nRESET;
    logic       ref_gnt;
    logic       ref_req;
    logic [3:0] nREF_RAS;
    logic [3:0] nREF_CAS;
    logic       ref_busy;
    logic       ref_done;
    logic       ref_overrun;

    int checks   = 0;
    int failures = 0;

    dram_refresh #(
        .REF_DIV (REF_DIV),
        .RAS_CLKS(RAS_CLKS),
        .PRE_CLKS(PRE_CLKS),
        .MAX_PEND(MAX_PEND)
    ) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .ref_gnt    (ref_gnt),
        .ref_req    (ref_req),
        .nREF_RAS   (nREF_RAS),
        .nREF_CAS   (nREF_CAS),
        .ref_busy   (ref_busy),
        .ref_done   (ref_done),
        .ref_overrun(ref_overrun)
    );

    always #5 clk = ~clk;

    // Packed view: {req, busy, done, overrun, ras[3:0], cas[3:0]}
    localparam logic [11:0] V_IDLE = 12'h0FF;
    localparam logic [11:0] V_REQ  = 12'h8FF;
    localparam logic [11:0] V_CAS  = 12'hCF0;
    localparam logic [11:0] V_RAS  = 12'hC00;
    localparam logic [11:0] V_PRE  = 12'hCFF;
    localparam logic [11:0] V_DONE = 12'h2FF;

    // Reference model: a refresh is a playlist of phases, 0=CAS 1=RAS 2=PRE 3=completion.
    int m_div;
    int m_pend;
    bit m_req;
    bit m_ovr;
    int m_cur;
    int m_seq[$];

    function automatic logic [11:0] dut_vec();
        return {ref_req, ref_busy, ref_done, ref_overrun, nREF_RAS, nREF_CAS};
    endfunction

    function automatic logic [11:0] model_vec();
        logic busy, done;
        logic [3:0] ras, cas;
        busy = (m_cur >= 0 && m_cur <= 2);
        done = (m_cur == 3);
        ras  = (m_cur == 1) ? 4'h0 : 4'hF;
        cas  = (m_cur == 0 || m_cur == 1) ? 4'h0 : 4'hF;
        return {m_req, busy, done, m_ovr, ras, cas};
    endfunction

    task automatic model_edge(input logic rst_n, input logic gnt);
        bit tick, fin;
        if (!rst_n) begin
            m_div = 0; m_pend = 0; m_req = 0; m_ovr = 0; m_cur = -1;
            m_seq.delete();
            return;
        end
        tick  = (m_div == REF_DIV - 1);
        m_div = (m_div + 1) % REF_DIV;
        fin   = 0;
        if (m_seq.size() != 0) begin
            m_cur = m_seq.pop_front();
            fin   = (m_cur == 3);
        end else begin
            m_cur = -1;
            if (m_req && gnt) begin
                m_seq.push_back(0);
                for (int i = 0; i < RAS_CLKS; i++) m_seq.push_back(1);
                for (int i = 0; i < PRE_CLKS; i++) m_seq.push_back(2);
                m_seq.push_back(3);
                m_cur = m_seq.pop_front();
            end else if (!m_req && m_pend != 0) begin
                m_req = 1;
            end
        end
        if (tick && !fin) begin
            if (m_pend == MAX_PEND) m_ovr = 1;
            else m_pend++;
        end else if (fin && !tick) begin
            m_pend--;
        end
        if (fin) m_req = (m_pend != 0);
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then compare.
    task automatic step();
        @(posedge clk);
        model_edge(nRESET, ref_gnt);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        repeat (3) step();
        nRESET = 1'b1;
    endtask

    typedef struct {
        int          edge_n;
        logic        gnt;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[12];
    int   n;
    int   dones;
    bit   ok;

    initial begin
        nRESET  = 1'b0;
        ref_gnt = 1'b0;

        // First refresh after reset with grant always present.
        tbl[0]  = '{14, 1'b1, V_IDLE};
        tbl[1]  = '{15, 1'b1, V_IDLE};
        tbl[2]  = '{16, 1'b1, V_IDLE};
        tbl[3]  = '{17, 1'b1, V_REQ};
        tbl[4]  = '{18, 1'b1, V_CAS};
        tbl[5]  = '{19, 1'b1, V_RAS};
        tbl[6]  = '{20, 1'b1, V_RAS};
        tbl[7]  = '{21, 1'b1, V_RAS};
        tbl[8]  = '{22, 1'b1, V_PRE};
        tbl[9]  = '{23, 1'b1, V_PRE};
        tbl[10] = '{24, 1'b1, V_DONE};
        tbl[11] = '{25, 1'b1, V_IDLE};

        do_reset();
        check("reset_state", dut_vec(), V_IDLE);
        ref_gnt = 1'b1;
        repeat (13) step();
        for (int i = 0; i < 12; i++) begin
            ref_gnt = tbl[i].gnt;
            step();
            check($sformatf("first_refresh_e%0d", tbl[i].edge_n), dut_vec(), tbl[i].exp);
        end

        // Backlog with grant withheld: saturation, sticky overrun, then drain.
        do_reset();
        ref_gnt = 1'b0;
        repeat (79) step();
        check_bit("no_overrun_at_max", ref_overrun, 1'b0);
        step();
        check_bit("overrun_5th_tick", ref_overrun, 1'b1);
        ref_gnt = 1'b1;
        dones = 0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (ref_done) dones++;
            if (!ref_req && dones > 0) ok = 1;
        end
        if (!ok) fail_timeout("drain_to_idle");
        check_bit("drained_at_least_4", dones >= 4, 1'b1);
        check_bit("overrun_sticky", ref_overrun, 1'b1);

        // Reset in the middle of the RAS pulse.
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (nREF_RAS == 4'h0) ok = 1;
        end
        if (!ok) fail_timeout("wait_ras_for_reset");
        nRESET = 1'b0;
        step();
        check("reset_mid_ras", dut_vec(), V_IDLE);
        nRESET = 1'b1;

        // Grant dropped during RAS: sequence still completes on schedule.
        do_reset();
        ref_gnt = 1'b1;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (nREF_RAS == 4'h0) ok = 1;
        end
        if (!ok) fail_timeout("wait_ras_for_drop");
        ref_gnt = 1'b0;
        n = 0;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            n++;
            if (ref_done) ok = 1;
        end
        if (!ok) fail_timeout("done_after_drop");
        else check("done_latency_after_drop", 12'(n), 12'(RAS_CLKS - 1 + PRE_CLKS + 1));

        // Completion on the same edge as a tick: count holds, straight back to REQ.
        do_reset();
        ref_gnt = 1'b0;
        repeat (25) step();
        check("waiting_in_req", dut_vec(), V_REQ);
        ref_gnt = 1'b1;
        repeat (6) step();
        step();
        check("done_on_tick_edge32", dut_vec(), 12'hAFF);
        step();
        check("regrant_edge33", dut_vec(), V_CAS);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) ref_gnt = ~ref_gnt;
            nRESET = ($urandom_range(0, 599) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
